// File: rtl/spi_master_multi.sv
// SPI master with one-of-NSS active-low selects, runtime CPOL/CPHA, bit order and clock divider.
// All transfer timing comes from one divider counter and one sck-edge counter.
module spi_master_multi #(
    parameter int DW  = 8,
    parameter int NSS = 16,
    parameter int SW  = 4,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           start,
    input  logic [SW-1:0]  sel,
    input  logic [DW-1:0]  tdat,
    input  logic           mlb,
    input  logic           cpol,
    input  logic           cpha,
    input  logic [CW-1:0]  cdiv,
    input  logic           din,
    output logic [NSS-1:0] ss,
    output logic           sck,
    output logic           dout,
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  rdata
);
    localparam int EW = $clog2(2 * DW);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, FIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   div_reg;
    logic [CW-1:0]   cdiv_reg;
    logic [EW-1:0]   edge_reg;
    logic [DW-1:0]   tx_reg;
    logic [DW-1:0]   rx_reg;
    logic            mlb_reg;
    logic            cpha_reg;
    logic            tick;
    logic [NSS-1:0]  ss_pick;

    // Out-of-range sel matches no line, so every select stays high.
    for (genvar gi = 0; gi < NSS; gi++) begin : g_ss
        assign ss_pick[gi] = (sel != SW'(gi));
    end

    function automatic logic head_bit(input logic [DW-1:0] w, input logic msb_first);
        return msb_first ? w[DW-1] : w[0];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic msb_first);
        return msb_first ? {w[DW-2:0], 1'b0} : {1'b0, w[DW-1:1]};
    endfunction

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic msb_first,
                                               input logic b);
        return msb_first ? {w[DW-2:0], b} : {b, w[DW-1:1]};
    endfunction

    assign tick = (div_reg == cdiv_reg);
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == FIN);

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LEAD;
            LEAD:    if (tick) state_next = XFER;
            XFER:    if (tick && edge_reg == LAST_EDGE) state_next = TRAIL;
            TRAIL:   if (tick) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            div_reg  <= '0;
            cdiv_reg <= '0;
            edge_reg <= '0;
            tx_reg   <= '0;
            rx_reg   <= '0;
            mlb_reg  <= 1'b0;
            cpha_reg <= 1'b0;
            ss       <= '1;
            sck      <= 1'b0;
            dout     <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    div_reg  <= '0;
                    edge_reg <= '0;
                    if (start) begin
                        cdiv_reg <= cdiv;
                        mlb_reg  <= mlb;
                        cpha_reg <= cpha;
                        sck      <= cpol;
                        ss       <= ss_pick;
                        rx_reg   <= '0;
                        // With cpha=0 the first bit must be set up before the first leading edge.
                        if (!cpha) begin
                            dout   <= head_bit(tdat, mlb);
                            tx_reg <= shift_out(tdat, mlb);
                        end else begin
                            tx_reg <= tdat;
                        end
                    end
                end
                LEAD: begin
                    div_reg <= tick ? '0 : div_reg + 1'b1;
                end
                XFER: begin
                    div_reg <= tick ? '0 : div_reg + 1'b1;
                    if (tick) begin
                        sck      <= ~sck;
                        edge_reg <= edge_reg + 1'b1;
                        // Even edge index = leading edge; cpha selects which kind samples.
                        if (edge_reg[0] == cpha_reg) begin
                            rx_reg <= shift_in(rx_reg, mlb_reg, din);
                        end else if (edge_reg != LAST_EDGE) begin
                            dout   <= head_bit(tx_reg, mlb_reg);
                            tx_reg <= shift_out(tx_reg, mlb_reg);
                        end
                    end
                end
                TRAIL: begin
                    div_reg <= tick ? '0 : div_reg + 1'b1;
                    if (tick) begin
                        rdata <= rx_reg;
                        ss    <= '1;
                        dout  <= 1'b0;
                    end
                end
                default: begin
                    div_reg <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: a slave model on the bus, a monitor that
// checks each done pulse against the queued expectation.
module tb_spi_master_multi;
    localparam int DW  = 8;
    localparam int NSS = 12;
    localparam int SW  = 4;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rstb = 1'b1;
    logic           start = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [DW-1:0]  tdat = '0;
    logic           mlb = 1'b1;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic [CW-1:0]  cdiv = '0;
    logic           din = 1'b0;
    logic [NSS-1:0] ss;
    logic           sck;
    logic           dout;
    logic           busy;
    logic           done;
    logic [DW-1:0]  rdata;

    spi_master_multi #(.DW(DW), .NSS(NSS), .SW(SW), .CW(CW)) dut (
        .clk(clk), .rstb(rstb), .start(start), .sel(sel), .tdat(tdat), .mlb(mlb),
        .cpol(cpol), .cpha(cpha), .cdiv(cdiv), .din(din), .ss(ss), .sck(sck),
        .dout(dout), .busy(busy), .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [7:0]     rd;
        logic [7:0]     mosi;
        int             lat;
        logic [NSS-1:0] ssp;
        logic           pol;
        int             gap;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] slave_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_pushed = 0;
    logic cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_mlb = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic sbit(input logic [7:0] w, input int k, input logic msb_first);
        return msb_first ? w[7-k] : w[k];
    endfunction

    // Slave model, MOSI capture and response monitor share one process so their ordering is fixed.
    exp_t           e;
    logic [7:0]     s_word, mosi_seq;
    int             s_idx, cyc, idle_cnt, gap_last;
    logic [NSS-1:0] ss_and, ss_or;
    logic           sck_prev, sck_lead, busy_prev, leading;

    always @(negedge clk) begin
        if (rstb) begin
            busy_prev = 1'b0;
            idle_cnt  = 0;
            cyc       = 0;
            s_idx     = 0;
            din       = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                gap_last = idle_cnt;
                idle_cnt = 0;
                cyc      = 1;
                ss_and   = ss;
                ss_or    = ss;
                sck_lead = sck;
                mosi_seq = '0;
                s_idx    = 0;
                s_word   = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
                if (!cfg_cpha) begin
                    din   = sbit(s_word, 0, cfg_mlb);
                    s_idx = 1;
                end
            end else if (busy) begin
                cyc++;
                if (!done) begin
                    ss_and = ss_and & ss;
                    ss_or  = ss_or | ss;
                end
                if (sck != sck_prev) begin
                    leading = (sck != cfg_cpol);
                    if (leading != cfg_cpha) begin
                        mosi_seq = {mosi_seq[6:0], dout};
                    end else begin
                        if (s_idx < 8) din = sbit(s_word, s_idx, cfg_mlb);
                        s_idx++;
                    end
                end
            end else begin
                idle_cnt++;
            end

            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("xfer %s: rdata=%02h mosi=%02h latency=%0d ss=%03h", e.name, rdata,
                             mosi_seq, cyc, ss_and);
                    check({e.name, "_rdata"},    {24'd0, rdata}, {24'd0, e.rd});
                    check({e.name, "_mosi"},     {24'd0, mosi_seq}, {24'd0, e.mosi});
                    check({e.name, "_latency"},  cyc, e.lat);
                    check({e.name, "_ss_low"},   {20'd0, ss_and}, {20'd0, e.ssp});
                    check({e.name, "_ss_high"},  {20'd0, ss_or}, {20'd0, e.ssp});
                    check({e.name, "_ss_fin"},   {20'd0, ss}, {20'd0, {NSS{1'b1}}});
                    check({e.name, "_sck_lead"}, {31'd0, sck_lead}, {31'd0, e.pol});
                    if (e.gap >= 0) check({e.name, "_idle_gap"}, gap_last, e.gap);
                end
            end
            busy_prev = busy;
        end
        sck_prev = sck;
    end

    task automatic expect_xfer(input string nm, input logic [7:0] sw, input logic [7:0] mo,
                               input int lat, input logic [NSS-1:0] ssp, input logic pol,
                               input int gap);
        exp_t x;
        x.name = nm; x.rd = sw; x.mosi = mo; x.lat = lat; x.ssp = ssp; x.pol = pol; x.gap = gap;
        sb.push_back(x);
        slave_q.push_back(sw);
        n_pushed++;
    endtask

    task automatic set_mode(input logic p, input logic h, input logic m, input logic [3:0] d,
                            input logic [3:0] s);
        cfg_cpol = p; cfg_cpha = h; cfg_mlb = m;
        cpol = p; cpha = h; mlb = m; cdiv = d; sel = s;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", nm, sb.size());
            sb.delete();
            slave_q.delete();
        end
    endtask

    task automatic wait_busy_rise(input string nm, input int budget);
        logic prev = busy;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy && !prev) return;
            prev = busy;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_busy_timeout: got busy=%0b, expected rise", nm, busy);
    endtask

    task automatic pulse_start(input logic [7:0] td);
        tdat  = td;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ss",    {20'd0, ss}, {20'd0, {NSS{1'b1}}});
        check("rst_sck",   {31'd0, sck}, 32'd0);
        check("rst_dout",  {31'd0, dout}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        rstb = 1'b0;
        @(negedge clk);

        // Mode 0, MSB first, fastest clock, slave 0.
        set_mode(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        expect_xfer("m0_sel0", 8'hAC, 8'h7C, 19, 12'hFFE, 1'b0, -1);
        pulse_start(8'h7C);
        wait_drain("m0_sel0", 200);
        @(negedge clk);

        // Reset during bit 4 aborts the transfer.
        set_mode(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        slave_q.push_back(8'h11);
        pulse_start(8'hF0);
        repeat (9) @(negedge clk);
        rstb = 1'b1;
        #1;
        check("abort_ss",    {20'd0, ss}, {20'd0, {NSS{1'b1}}});
        check("abort_sck",   {31'd0, sck}, 32'd0);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_done",  {31'd0, done}, 32'd0);
        check("abort_dout",  {31'd0, dout}, 32'd0);
        check("abort_rdata", {24'd0, rdata}, 32'd0);
        @(negedge clk);
        rstb = 1'b0;
        slave_q.delete();
        repeat (40) @(negedge clk);
        check("abort_rdata_hold", {24'd0, rdata}, 32'd0);

        // Mode 3, LSB first, H=2, slave 2; first start after reset takes sck high.
        set_mode(1'b1, 1'b1, 1'b0, 4'd1, 4'd2);
        expect_xfer("m3_lsb_sel2", 8'h5A, 8'h38, 37, 12'hFFB, 1'b1, -1);
        pulse_start(8'h1C);
        wait_drain("m3_lsb_sel2", 200);
        repeat (3) @(negedge clk);
        check("m3_sck_idle", {31'd0, sck}, 32'd1);

        // Start held high: three back-to-back transfers, one idle cycle apart.
        set_mode(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        expect_xfer("b2b_0", 8'h81, 8'h1C, 19, 12'hFFE, 1'b0, -1);
        expect_xfer("b2b_1", 8'h7E, 8'hE3, 19, 12'hFFE, 1'b0, 1);
        expect_xfer("b2b_2", 8'h42, 8'h1C, 19, 12'hFFE, 1'b0, 1);
        tdat  = 8'h1C;
        start = 1'b1;
        wait_busy_rise("b2b_0", 50);
        tdat = 8'hE3;
        wait_busy_rise("b2b_1", 50);
        tdat = 8'h1C;
        wait_busy_rise("b2b_2", 50);
        start = 1'b0;
        wait_drain("b2b", 200);
        @(negedge clk);

        // sel beyond NSS: no select asserted, nominal timing, rdata from din.
        set_mode(1'b0, 1'b1, 1'b1, 4'd2, 4'd13);
        expect_xfer("m1_sel13", 8'h96, 8'hA5, 55, 12'hFFF, 1'b0, -1);
        pulse_start(8'hA5);
        wait_drain("m1_sel13", 300);
        @(negedge clk);

        // Start pulsed mid-transfer is dropped.
        set_mode(1'b1, 1'b0, 1'b1, 4'd0, 4'd1);
        expect_xfer("m2_busy_start", 8'h3C, 8'h55, 19, 12'hFFD, 1'b1, -1);
        pulse_start(8'h55);
        repeat (5) @(negedge clk);
        pulse_start(8'hFF);
        wait_drain("m2_busy_start", 200);
        repeat (40) @(negedge clk);
        check("done_count", n_done, n_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
